// File: rtl/fir_result_serializer.sv
// fir_result_serializer: takes FIR result words over valid/ready and sends them MSB first, framed by ser_frame/ser_last.
// Optional build macro FIR_SER_PARITY_EN appends one even-parity bit per frame.
module fir_result_serializer #(
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ser_en,
  output logic              ser_out,
  output logic              ser_frame,
  output logic              ser_last,
  output logic              busy
);

  localparam int            CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

`ifdef FIR_SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] hold_reg, hold_next;
  logic              hold_full_reg, hold_full_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              frame_end;
  logic              accept;
  logic              out_next, last_next;
`ifdef FIR_SER_PARITY_EN
  logic              par_reg, par_next;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    cnt_next       = cnt_reg;
    frame_end      = 1'b0;
`ifdef FIR_SER_PARITY_EN
    par_next       = par_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          shift_next = in_data;
          cnt_next   = '0;
`ifdef FIR_SER_PARITY_EN
          par_next   = ^in_data;
`endif
        end
      end
      SHIFT: begin
        if (ser_en) begin
          if (cnt_reg == CNT_LAST) begin
`ifdef FIR_SER_PARITY_EN
            state_next = PARITY;
`else
            frame_end  = 1'b1;
`endif
          end else begin
            shift_next = shift_reg << 1;
            cnt_next   = cnt_reg + 1'b1;
          end
        end
      end
`ifdef FIR_SER_PARITY_EN
      PARITY: begin
        if (ser_en) frame_end = 1'b1;
      end
`endif
      default: state_next = IDLE;
    endcase

    // Frame boundary: the buffered word wins over a same-edge accept so order is preserved.
    if (frame_end) begin
      if (hold_full_reg) begin
        state_next     = SHIFT;
        shift_next     = hold_reg;
        cnt_next       = '0;
        hold_full_next = 1'b0;
`ifdef FIR_SER_PARITY_EN
        par_next       = ^hold_reg;
`endif
      end else if (accept) begin
        state_next = SHIFT;
        shift_next = in_data;
        cnt_next   = '0;
`ifdef FIR_SER_PARITY_EN
        par_next   = ^in_data;
`endif
      end else begin
        state_next = IDLE;
      end
    end else if (accept && state_reg != IDLE) begin
      hold_next      = in_data;
      hold_full_next = 1'b1;
    end

    out_next  = 1'b0;
    last_next = 1'b0;
    case (state_next)
      SHIFT: begin
        out_next = shift_next[DATA_W-1];
`ifndef FIR_SER_PARITY_EN
        last_next = (cnt_next == CNT_LAST);
`endif
      end
`ifdef FIR_SER_PARITY_EN
      PARITY: begin
        out_next  = par_next;
        last_next = 1'b1;
      end
`endif
      default: begin
        out_next  = 1'b0;
        last_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      cnt_reg       <= '0;
`ifdef FIR_SER_PARITY_EN
      par_reg       <= 1'b0;
`endif
      in_ready      <= 1'b1;
      busy          <= 1'b0;
      ser_out       <= 1'b0;
      ser_frame     <= 1'b0;
      ser_last      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      cnt_reg       <= cnt_next;
`ifdef FIR_SER_PARITY_EN
      par_reg       <= par_next;
`endif
      // Outputs are registered from next-state values so they line up with the state they describe.
      in_ready      <= !hold_full_next;
      busy          <= (state_next != IDLE) || hold_full_next;
      ser_out       <= out_next;
      ser_frame     <= (state_next != IDLE);
      ser_last      <= last_next;
    end
  end

endmodule

// File: tb/tb_fir_result_serializer.sv
`timescale 1ns/1ps
// Bench for fir_result_serializer: vector table, back-to-back/buffer/reset sequences and a random scoreboard run.
module tb_fir_result_serializer;

  localparam int W = 20;
`ifdef FIR_SER_PARITY_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif
  localparam int NB = W + PX;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         ser_en = 1'b1;
  logic         ser_out;
  logic         ser_frame;
  logic         ser_last;
  logic         busy;

  always #5 clk = ~clk;

  fir_result_serializer #(.DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ser_en   (ser_en),
    .ser_out  (ser_out),
    .ser_frame(ser_frame),
    .ser_last (ser_last),
    .busy     (busy)
  );

  typedef struct {
    logic [W-1:0] data;
    int           stall_bit;
    int           stall_len;
    int           exp_len;
    logic         exp_par;
  } vec_t;

  vec_t         vecs[5];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];

  int           bit_idx = 0;
  int           frame_len = 0;
  int           run_len = 0;
  int           max_run = 0;
  int           frames_done = 0;
  int           last_len = 0;
  logic [W-1:0] word_acc = '0;
  logic [W-1:0] mon_exp = '0;
  logic         par_bit = 1'b0;
  logic         last_par = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a bit is consumed on the next rising edge when ser_frame and ser_en are both high.
  always @(negedge clk) begin
    if (!rst) begin
      bit_idx   = 0;
      frame_len = 0;
      run_len   = 0;
      word_acc  = '0;
    end else if (!ser_frame) begin
      run_len = 0;
      check("idle_outputs", 32'({bit_idx != 0, ser_out, ser_last}), 32'd0);
    end else begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      frame_len++;
      check("ser_last", 32'(ser_last), 32'(bit_idx == NB - 1));
      if (ser_en) begin
        if (bit_idx < W) word_acc = {word_acc[W-2:0], ser_out};
        else par_bit = ser_out;
        bit_idx++;
        if (bit_idx == NB) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got %05h expected no frame", word_acc);
          end else begin
            mon_exp = exp_q.pop_front();
            check("frame_data", 32'(word_acc), 32'(mon_exp));
`ifdef FIR_SER_PARITY_EN
            check("parity_bit", 32'(par_bit), 32'(^mon_exp));
`endif
            $display("frame %0d: data %05h expected %05h len %0d", frames_done, word_acc, mon_exp, frame_len);
          end
          last_len    = frame_len;
          last_par    = par_bit;
          frames_done++;
          bit_idx     = 0;
          frame_len   = 0;
        end
      end
    end
  end

  // Called and returns at 1ns after a rising edge; the word is accepted on the edge inside.
  task automatic send(input logic [W-1:0] d);
    int t;
    t = 0;
    while (!in_ready && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready %0b required 1", in_ready);
    end
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(d);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (frames_done < target && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("frames_reached", 32'(frames_done >= target), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d frames", frames_done);
    $fatal(1, "watchdog");
  end

  initial begin
    int   target;
    int   sent;
    int   cyc;
    logic acc;

    vecs[0] = '{20'hA5A5A, 0, 0, NB,     1'b0};
    vecs[1] = '{20'h80001, 7, 3, NB + 3, 1'b0};
    vecs[2] = '{20'h00001, 0, 0, NB,     1'b1};
    vecs[3] = '{20'h00003, 0, 0, NB,     1'b0};
    vecs[4] = '{20'hFFFFF, 0, 0, NB,     1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ser_out",   32'(ser_out),   32'd0);
    check("rst_ser_frame", 32'(ser_frame), 32'd0);
    check("rst_ser_last",  32'(ser_last),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      target = frames_done + 1;
      send(vecs[i].data);
      check("latency_frame", 32'(ser_frame), 32'd1);
      check("latency_msb", 32'(ser_out), 32'(vecs[i].data[W-1]));
      if (vecs[i].stall_len > 0) begin
        repeat (vecs[i].stall_bit) @(posedge clk);
        #1;
        ser_en = 1'b0;
        repeat (vecs[i].stall_len) @(posedge clk);
        #1;
        check("stall_hold", 32'(ser_out), 32'(vecs[i].data[W-1-vecs[i].stall_bit]));
        ser_en = 1'b1;
      end
      wait_frames(target);
      check("frame_len", 32'(last_len), 32'(vecs[i].exp_len));
`ifdef FIR_SER_PARITY_EN
      check("parity_value", 32'(last_par), 32'(vecs[i].exp_par));
`endif
      repeat (2) @(posedge clk);
      #1;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ready", 32'(in_ready), 32'd1);
    end

    // Back-to-back frames with a third word held off while the buffer is full.
    target  = frames_done + 3;
    max_run = 0;
    send(20'hFFFFF);
    send(20'h00000);
    check("b2b_ready_low", 32'(in_ready), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    in_data  = 20'h12345;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("full_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    send(20'h12345);
    wait_frames(target);
    check("b2b_last_len", 32'(last_len), 32'(NB));
    check("b2b_continuous", 32'(max_run), 32'(3 * NB));

    // Reset mid-frame with a word sitting in the buffer.
    send(20'hABCDE);
    send(20'h13579);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_ser_out",   32'(ser_out),   32'd0);
    check("mid_rst_ser_frame", 32'(ser_frame), 32'd0);
    check("mid_rst_ser_last",  32'(ser_last),  32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst    = 1'b1;
    target = frames_done + 1;
    send(20'h00003);
    wait_frames(target);
    check("post_rst_len", 32'(last_len), 32'(NB));
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(busy), 32'd0);

    // Random words under random ser_en and in_valid.
    sent   = 0;
    cyc    = 0;
    target = frames_done + 100;
    while ((sent < 100 || frames_done < target) && cyc < 20000) begin
      ser_en   = ($urandom_range(0, 3) != 0);
      in_valid = (sent < 100) && ($urandom_range(0, 2) != 0);
      in_data  = W'($urandom);
      acc      = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(in_data);
        sent++;
      end
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    ser_en   = 1'b1;
    check("rand_sent", 32'(sent), 32'd100);
    check("rand_frames", 32'(frames_done), 32'(target));
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
